// File: rtl/aes_key_schedule_ctrl_pkg.sv
// aes_key_schedule_ctrl_pkg: shared AES-128 key-schedule types, constants and byte helpers.
// Contents:
//   AES_NR      number of rounds (10), so the bank holds AES_NR+1 round keys
//   rk_t        128-bit round key
//   rk_idx_t    4-bit round-key index / round-constant counter
//   ks_state_e  key-schedule FSM state encoding
//   RCON_TAB    round constants for rc 0..9
//   SBOX_TAB    forward AES S-box, entry 0 in the most significant byte
package aes_key_schedule_ctrl_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] rk_t;
    typedef logic [3:0]   rk_idx_t;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_WAIT = 2'd1,
        KS_CAPT = 2'd2
    } ks_state_e;

    localparam logic [79:0] RCON_TAB = 80'h01_02_04_08_10_20_40_80_1b_36;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TAB[2047 - 8 * int'(x) -: 8];
    endfunction

    // Indices above 9 fall back to zero; the sequencer never produces them.
    function automatic logic [7:0] rcon(input rk_idx_t rc);
        return (rc < 4'd10) ? RCON_TAB[79 - 8 * int'(rc) -: 8] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// aes_key_schedule_ctrl_if: request / status / read-port bundle of the key-schedule sequencer.
// Signals:
//   start      request a new expansion (sampled only while idle)
//   key_in     128-bit cipher key, sampled with an accepted start
//   busy       expansion in progress
//   done       one-cycle pulse when the last round key is written
//   key_valid  bank holds a complete schedule
//   rk_addr    round-key read index 0..10
//   rk_data    registered read data for rk_addr
// Modports: master drives requests and reads (round engines, bench), slave is the sequencer.
interface aes_key_schedule_ctrl_if;
    import aes_key_schedule_ctrl_pkg::*;

    logic    start;
    rk_t     key_in;
    logic    busy;
    logic    done;
    logic    key_valid;
    rk_idx_t rk_addr;
    rk_t     rk_data;

    modport master (
        output start, key_in, rk_addr,
        input  busy, done, key_valid, rk_data
    );

    modport slave (
        input  start, key_in, rk_addr,
        output busy, done, key_valid, rk_data
    );

endinterface

// File: rtl/aes_key_schedule_ctrl_keygen.sv
// KeyGeneration: one AES-128 key-expansion round with a SBOX_LAT-deep registered S-box path.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset of the S-box pipeline
//   key         previous round key; must stay stable for SBOX_LAT cycles before keyout is used
//   rc          round-constant index 0..9
//   keyout      next round key
module KeyGeneration
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rk_t     key,
    input  rk_idx_t rc,
    output rk_t     keyout
);

    logic [31:0] rot;
    logic [31:0] sub_c;
    logic [31:0] sub;
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    assign rot   = {key[23:0], key[31:24]};
    assign sub_c = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign sub = sub_c;
        end else begin : g_pipe
            logic [31:0] pipe [SBOX_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SBOX_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= sub_c;
                    for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign sub = pipe[SBOX_LAT-1];
        end
    endgenerate

    // rc is held stable alongside key, so the round constant can stay combinational.
    assign t      = sub ^ {rcon(rc), 24'h000000};
    assign w0     = key[127:96] ^ t;
    assign w1     = key[95:64] ^ w0;
    assign w2     = key[63:32] ^ w1;
    assign w3     = key[31:0] ^ w2;
    assign keyout = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: sequences the AES-128 key expansion and keeps all eleven round keys readable by index.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; clears FSM, status and the whole key bank
//   bus    slave side of aes_key_schedule_ctrl_if (start/key_in request, busy/done/key_valid
//          status, rk_addr -> rk_data registered read with 1-cycle latency, 0 beyond index 10)
// Parameter:
//   SBOX_LAT  registered S-box latency of KeyGeneration, 0..3; each round costs SBOX_LAT+1 cycles
module aes_key_schedule_ctrl
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    aes_key_schedule_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = KS_IDLE;
    localparam logic [1:0] WAIT = KS_WAIT;
    localparam logic [1:0] CAPT = KS_CAPT;
    // With a combinational S-box there is nothing to wait for, so rounds chain CAPT to CAPT.
    localparam logic [1:0] NXT   = (SBOX_LAT == 0) ? CAPT : WAIT;
    localparam logic [1:0] WLAST = (SBOX_LAT == 0) ? 2'd0 : 2'(SBOX_LAT - 1);

    logic [1:0] state;
    logic [1:0] wcnt;
    rk_t        cur;
    rk_idx_t    rc;
    rk_t        keyout;
    rk_t        rk [AES_NR+1];
    logic       busy;
    logic       done;
    logic       key_valid;
    rk_t        rk_data;

    KeyGeneration #(.SBOX_LAT(SBOX_LAT)) u_keygen (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (cur),
        .rc     (rc),
        .keyout (keyout)
    );

    // cur and rc are only written in IDLE (accept) and CAPT, never in WAIT,
    // so the S-box pipeline sees a stable operand for the whole wait interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            cur       <= '0;
            rc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            rk_data   <= '0;
            for (int i = 0; i <= AES_NR; i++) rk[i] <= '0;
        end else begin
            done    <= 1'b0;
            rk_data <= (bus.rk_addr <= rk_idx_t'(AES_NR)) ? rk[bus.rk_addr] : '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rk[0]     <= bus.key_in;
                        cur       <= bus.key_in;
                        rc        <= '0;
                        wcnt      <= '0;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= NXT;
                    end
                end
                WAIT: begin
                    if (wcnt == WLAST) begin
                        wcnt  <= '0;
                        state <= CAPT;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                CAPT: begin
                    rk[rk_idx_t'(rc + 4'd1)] <= keyout;
                    cur                      <= keyout;
                    if (rc == rk_idx_t'(AES_NR - 1)) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rc    <= rc + 4'd1;
                        state <= NXT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.key_valid = key_valid;
    assign bus.rk_data   = rk_data;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: directed checks of the key-schedule sequencer against FIPS-197 vectors.
module tb_aes_key_schedule_ctrl;
    import aes_key_schedule_ctrl_pkg::*;

    localparam rk_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam rk_t ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

    localparam rk_t FIPS_RK [16] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
        128'h0, 128'h0, 128'h0, 128'h0, 128'h0
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    int   n;
    int   dcnt;

    always #5 clk = ~clk;

    aes_key_schedule_ctrl_if bus ();

    aes_key_schedule_ctrl #(.SBOX_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start_key(input rk_t k);
        @(negedge clk);
        bus.key_in = k;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic rd(input int a, input rk_t exp, input string tag);
        bus.rk_addr = 4'(a);
        @(negedge clk);
        chk(tag, bus.rk_data, exp);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.key_in  = '0;
        bus.rk_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_done", 128'(bus.done), 128'(0));
        chk("reset_key_valid", 128'(bus.key_valid), 128'(0));
        chk("reset_rk_data", bus.rk_data, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 key, with a different-key start injected while busy
        start_key(FIPS_KEY);
        chk("accept_busy", 128'(bus.busy), 128'(1));
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.key_in = (n == 6) ? ALT_KEY : FIPS_KEY;
            bus.start  = (n == 6);
        end
        bus.start = 1'b0;
        chk("fips_latency", 128'(n), 128'(20));
        chk("fips_done_busy", 128'(bus.busy), 128'(0));
        chk("fips_done_kv", 128'(bus.key_valid), 128'(1));
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        chk("single_done", 128'(dcnt), 128'(0));
        rd(0, FIPS_KEY, "fips_rk0");
        rd(1, FIPS_RK[1], "fips_rk1");
        rd(10, FIPS_RK[10], "fips_rk10");

        // back-to-back: zero key accepted in the done cycle
        start_key(FIPS_KEY);
        wait_done(n);
        chk("b2b_first_latency", 128'(n), 128'(20));
        bus.key_in = '0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("b2b_kv_drop", 128'(bus.key_valid), 128'(0));
        chk("b2b_busy", 128'(bus.busy), 128'(1));
        wait_done(n);
        chk("b2b_latency", 128'(n), 128'(20));
        chk("b2b_kv_rise", 128'(bus.key_valid), 128'(1));
        rd(0, 128'h0, "zero_rk0");
        rd(1, 128'h62636363626363636263636362636363, "zero_rk1");
        rd(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // reset in the middle of an expansion
        start_key(FIPS_KEY);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_kv", 128'(bus.key_valid), 128'(0));
        chk("rst_rk_data", bus.rk_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a <= 10; a++) rd(a, 128'h0, $sformatf("rst_bank%0d", a));

        // fresh expansion after reset, then a full address sweep
        start_key(FIPS_KEY);
        wait_done(n);
        chk("fresh_latency", 128'(n), 128'(20));
        for (int a = 0; a < 16; a++) rd(a, FIPS_RK[a], $sformatf("sweep_rk%0d", a));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
